// File: rtl/video_native_to_axis_if.sv
// AXI4-Stream pixel bus between the native-video ingress stage and the VDMA write port.
interface video_native_to_axis_if #(
   parameter int DSIZE = 24
);
   logic [DSIZE-1:0] axi_tdata;
   logic             axi_tvalid;
   logic             axi_tready;
   logic             axi_tuser;
   logic             axi_tlast;

   modport master (
      output axi_tdata, axi_tvalid, axi_tuser, axi_tlast,
      input  axi_tready
   );

   modport slave (
      input  axi_tdata, axi_tvalid, axi_tuser, axi_tlast,
      output axi_tready
   );
endinterface

// File: rtl/video_native_to_axis.sv
// Native video (vsync/de/data) to AXI4-Stream ingress: tags SOF/EOL, buffers in a
// small FWFT FIFO, and drops the rest of a frame on overflow until the next vsync.
module video_native_to_axis #(
   parameter int DSIZE      = 24,
   parameter int FIFO_DEPTH = 16,
   parameter int VS_POL     = 1
) (
   input  logic                          clock,
   input  logic                          rst,
   input  logic [15:0]                   hactive,
   input  logic                          vsync,
   input  logic                          de,
   input  logic [DSIZE-1:0]              idata,
   video_native_to_axis_if.master        axis,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   output logic                          line_err,
   input  logic                          err_clr
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = DSIZE + 2;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {WAIT_SOF, ARMED, ACTIVE, DROP} state_t;

   state_t           state;
   logic             vs_q;
   logic             vs_act;
   logic             sof_evt;

   logic             hold_valid;
   logic [DSIZE-1:0] hold_data;
   logic             hold_sof;
   logic [15:0]      pix_cnt;

   logic [EW-1:0]    mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count_next;
   logic             tvalid_q;

   logic             push_eol;
   logic             full;
   logic             pop;
   logic             drop;
   logic             wr_en;
   logic             capture;
   logic             line_bad;

   // Frame start is the transition of vsync into its active level.
   assign vs_act  = (vsync == (VS_POL != 0));
   assign sof_evt = vs_act & ~vs_q;

   // The held pixel ends its line when de falls or a new frame begins under it.
   assign push_eol = ~de | sof_evt;
   assign full     = (fifo_count == FULL_CNT);
   assign pop      = tvalid_q & axis.axi_tready;
   assign drop     = hold_valid & full & ~pop;
   assign wr_en    = hold_valid & ~drop;
   assign capture  = de & ~sof_evt & ~drop & ((state == ARMED) | (state == ACTIVE));
   assign line_bad = wr_en & push_eol & (hactive != 16'd0) &
                     (({1'b0, pix_cnt} + 17'd1) != {1'b0, hactive});

   always_comb begin
      // NOTE: default first so every path assigns count_next and no latch is inferred.
      count_next = fifo_count;
      if (wr_en && !pop)
         count_next = fifo_count + CW'(1);
      else if (!wr_en && pop)
         count_next = fifo_count - CW'(1);
   end

   // NOTE: storage is deliberately not reset; only pointers and occupancy are,
   // which keeps the array in plain flops/LUTRAM and still makes it look empty.
   always_ff @(posedge clock) begin
      if (wr_en)
         mem[wr_ptr] <= {hold_data, hold_sof, push_eol};
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         tvalid_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         if (wr_en)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         fifo_count <= count_next;
         tvalid_q   <= (count_next != '0);
      end
   end

   // Outputs are forced low while nothing is queued so reset shows an all-zero bus.
   assign axis.axi_tvalid = tvalid_q;
   assign {axis.axi_tdata, axis.axi_tuser, axis.axi_tlast} = tvalid_q ? mem[rd_ptr] : '0;

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state      <= WAIT_SOF;
         vs_q       <= 1'b0;
         hold_valid <= 1'b0;
         hold_data  <= '0;
         hold_sof   <= 1'b0;
         pix_cnt    <= '0;
         overflow   <= 1'b0;
         line_err   <= 1'b0;
      end else begin
         vs_q <= vs_act;

         // A new error in the same cycle as err_clr keeps the flag set.
         if (drop)
            overflow <= 1'b1;
         else if (err_clr)
            overflow <= 1'b0;

         if (line_bad)
            line_err <= 1'b1;
         else if (err_clr)
            line_err <= 1'b0;

         if (drop || sof_evt)
            pix_cnt <= '0;
         else if (wr_en)
            pix_cnt <= push_eol ? 16'd0 : pix_cnt + 16'd1;

         hold_valid <= capture;
         if (capture) begin
            hold_data <= idata;
            hold_sof  <= (state == ARMED);
         end

         if (sof_evt)
            state <= ARMED;
         else begin
            case (state)
               ARMED:   if (de)   state <= ACTIVE;
               ACTIVE:  if (drop) state <= DROP;
               default: state <= state;
            endcase
         end
      end
   end

endmodule

// File: doc/video_native_to_axis.md
Name: video_native_to_axis

Overview:
- Ingress stage that converts a native video stream (vsync/hsync/de/data) into the AXI4-Stream pixel stream consumed by the VDMA write path on its AXIS input.
- Marks start-of-frame on tuser and end-of-line on tlast, and buffers pixels in a small FIFO to absorb tready back-pressure.
- Overflow drops the remainder of the frame and resynchronises on the next vsync, so the VDMA never receives a torn frame.

Parameters:
- DSIZE, 24, pixel width in bits.
- FIFO_DEPTH, 16, FIFO entries; power of two, minimum 4.
- VS_POL, 1, vsync active level (1 = active-high, 0 = active-low).

Ports:
- clock, input, 1, pixel/stream clock; single clock domain.
- rst, input, 1, asynchronous active-high reset.
- hactive, input, 16, expected pixels per line; used for the line-length check only.
- vsync, input, 1, native vertical sync; polarity set by VS_POL.
- de, input, 1, native data enable.
- idata, input, DSIZE, native pixel data, sampled when de=1.
- axi_tdata, output, DSIZE, stream pixel.
- axi_tvalid, output, 1, stream valid.
- axi_tready, input, 1, stream ready.
- axi_tuser, output, 1, start of frame; 1 on the first pixel of a frame.
- axi_tlast, output, 1, end of line; 1 on the last pixel of each line.
- fifo_count, output, $clog2(FIFO_DEPTH)+1, current FIFO occupancy.
- overflow, output, 1, sticky; set when a pixel is dropped because the FIFO is full.
- line_err, output, 1, sticky; set when a completed line length differs from hactive.
- err_clr, input, 1, single-cycle pulse that clears overflow and line_err.

Behaviour:
- Reset: all outputs 0; FIFO empty; hold register invalid; FSM in WAIT_SOF; pixel counter 0.
- Vsync edge: the frame-start event is the vsync transition into its active level, detected against a registered copy of vsync.
- Hold register: each pixel with de=1 is captured as {data, sof}.
  - If the next cycle also has de=1, the held pixel is pushed with eol=0.
  - If the next cycle has de=0, the held pixel is pushed with eol=1.
  - Consequently the push occurs exactly 1 cycle after the pixel's de cycle.
- FIFO: synchronous, registered output, first-word fall-through.
  - Empty FIFO: tvalid rises 2 cycles after the pixel's de cycle.
  - Pop occurs when tvalid && tready.
  - Simultaneous push and pop when full is allowed; occupancy stays at FIFO_DEPTH and nothing is dropped.
  - tdata/tuser/tlast are stable while tvalid=1 and tready=0.
- FSM states:
  - WAIT_SOF: discard all de pixels. On the frame-start event, go to ARMED.
  - ARMED: the first de pixel is tagged sof=1 and counting starts; go to ACTIVE.
  - ACTIVE: pixels are tagged sof=0. A push attempted while the FIFO is full (and no pop that cycle) drops the pixel, sets overflow and goes to DROP. A frame-start event goes to ARMED.
  - DROP: discard all pixels, including any hold-register content. Already-queued FIFO data still drains. A frame-start event goes to ARMED.
- Line check:
  - The pixel counter increments on each de pixel accepted in ARMED/ACTIVE and resets at eol.
  - At an eol push, if count+1 != hactive, set line_err.
  - hactive=0 disables the check.
- Frame-start event with the hold register valid (de still high across vsync): push the held pixel with eol=1, then tag the next pixel as sof.
- err_clr and a new error in the same cycle: the error wins and the flag stays 1.
- Reset asserted mid-frame: FIFO flushed, tvalid=0 immediately (asynchronous); the block waits for the next vsync.

Test Plan:
- Reset, then 2 frames of 4 lines x 8 pixels, tready=1 constantly, hactive=8 -> 64 beats; tuser=1 only on beats 0 and 32; tlast on every 8th beat; data order preserved; tvalid first rises 2 cycles after the first de.
- Same stimulus with tready toggling 1-0 (50 %), FIFO_DEPTH=16 -> no overflow; all 32 pixels of each frame delivered; tdata held stable while tready=0.
- tready=0 for an entire 64-pixel line -> first 16 pixels stay queued; overflow=1; rest of the frame dropped; next frame delivered fully with tuser=1 on its first beat.
- de pulses of 7 pixels with hactive=8 -> line_err=1 after the first line; err_clr pulse -> 0; a following correct 8-pixel line leaves it at 0.
- Pixels arriving before the first vsync after reset -> no beats output; output starts at the pixel after vsync with tuser=1.
- rst pulsed mid-line with 5 entries queued -> fifo_count=0 and tvalid=0 within the same cycle; no output until the next vsync.
